keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Scans the 4x4 score-entry keypad matrix, debounces presses and presents each accepted key to `counter` as a one-hot `key_row`/`key_column` pair, held for as long as the key stays down. It is the producing end of the keypad code interface that `counter` consumes: a team-select key such as row 1000, column 0001, followed by a points key such as row 0001, column 0010. Outputs are 4'b0000 whenever no key is accepted.

## Interface
- `SCAN_DIV`, default 16: clock cycles per scan slot (one row driven per slot); minimum 4.
- `DEBOUNCE_CNT`, default 4: consecutive matching slot samples required to accept a press or a release; minimum 1.
- `STUCK_SCANS`, default 64: HOLD slot samples before a key is declared stuck; only used with `KEYPAD_STUCK_DET_EN`.
- `clk_in`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `row_drive`  out  4  one-hot active-high drive to matrix rows.
- `col_sense`  in  4  matrix columns, active-high, asynchronous to `clk_in`.
- `key_row`  out  4  one-hot row of the accepted key; 0000 when idle.
- `key_column`  out  4  one-hot column of the accepted key; 0000 when idle.
- `key_valid`  out  1  one-cycle pulse when a new key is accepted.
- `key_stuck`  out  1  stuck-key flag; present only with `KEYPAD_STUCK_DET_EN`.

## Operation
- **Column synchronizer:** `col_sense` passes through a 2-flop synchronizer; all decisions use the synchronized value `cs`.
- **Slot counter:** free-running, 0..SCAN_DIV-1. The sample point is the cycle where the counter equals SCAN_DIV-1.
- **SCAN:**
  - At each sample point, `row_drive` rotates 0001→0010→0100→1000→0001.
  - If `cs` is exactly one-hot, the current row and `cs` are captured as the candidate and the state goes to DEBOUNCE with `row_drive` frozen.
  - `cs` of 0000, or with two or more bits set (ghosting), is ignored and scanning continues.
- **DEBOUNCE:** `row_drive` stays at the candidate row. Each sample point compares `cs` with the candidate.
  - Match: the match count increments.
  - Mismatch: return to SCAN, with `row_drive` advancing to the next row.
  - On the DEBOUNCE_CNT-th match: go to HOLD, register `key_row`/`key_column` = candidate and pulse `key_valid`.
- **HOLD:** outputs are held.
  - Any sample with the candidate column bit set resets the release count. Other column bits are ignored, so no second key is accepted while one is held.
  - DEBOUNCE_CNT consecutive samples with the candidate bit clear: go to RELEASE.
- **RELEASE:** lasts one cycle. `key_row`/`key_column` are cleared to 0000, then the state goes to SCAN with `row_drive` = 0001 and the slot counter restarted at 0.
- **Reset (asynchronous):** `row_drive`=0001, `key_row`=`key_column`=0000, `key_valid`=0, `key_stuck`=0, state SCAN, all counters and synchronizer flops 0. A mid-HOLD reset clears the outputs immediately.
- **Counter widths:** slot counter is $clog2(SCAN_DIV) bits; match/release counters are $clog2(DEBOUNCE_CNT+1) bits. They saturate and never wrap.

## Timing
- `col_sense` to `cs` latency: 2 cycles.
- **Press acceptance:** from the capture sample point, DEBOUNCE_CNT×SCAN_DIV cycles. `key_valid` is high and the outputs are valid in the cycle after the final matching sample edge.
- **Release:** outputs read 0000 one cycle after the DEBOUNCE_CNT-th clear sample.
- **Maximum press-to-accept latency** for a clean press: 4×SCAN_DIV + DEBOUNCE_CNT×SCAN_DIV + 3 cycles.
- At most one `key_valid` pulse per HOLD entry. `key_valid` is never high while outputs are 0000.
- A new press can be accepted no earlier than SCAN_DIV cycles after RELEASE.

## Configuration
- **`KEYPAD_STUCK_DET_EN` defined:**
  - A HOLD sample counter increments per sample point. On reaching STUCK_SCANS, `key_stuck` goes to 1 and `key_row`/`key_column` are forced to 0000; the state remains HOLD until release.
  - On release detection, `key_stuck` clears in the RELEASE cycle.
- **`KEYPAD_STUCK_DET_EN` undefined:** the `key_stuck` port and its logic are absent, and a held key drives the outputs indefinitely.

## Test plan
- **Reset:** assert `rst_n`=0 mid-slot → `row_drive`=0001, `key_row`/`key_column`=0000, `key_valid`=0 asynchronously; after release, rotation is 0001→0010 after 16 cycles.
- **Clean press:** matrix model returns `col_sense`=0001 while `row_drive`=1000, held for 20 slots → exactly one `key_valid` pulse; `key_row`=1000, `key_column`=0001 until 4 clear samples after release, then 0000.
- **Bounce:** key toggles each slot for 3 slots then opens → no `key_valid`, outputs stay 0000, scanning resumes.
- **Ghosting / second key:**
  - `col_sense`=0011 on row 0001 → ignored.
  - Hold row 0001 col 0010, then add col 0100 → outputs stay 0001/0010, with no second pulse.
- **Reset mid-HOLD:** key row 0100 col 0100 accepted, then pulse `rst_n` low → outputs 0000 immediately; the re-press is re-debounced and produces a fresh `key_valid`.
- **Stuck key (with `KEYPAD_STUCK_DET_EN`):** hold row 0001 col 0001 for 70 slots → `key_stuck`=1 after 64 HOLD samples, outputs 0000, no extra `key_valid`; release → `key_stuck`=0.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 keypad matrix scanner with column synchronizer, press/release debounce and
// one-hot key code output. Optional stuck-key detection via `KEYPAD_STUCK_DET_EN.
module keypad_scanner #(
    parameter int SCAN_DIV     = 16,
    parameter int DEBOUNCE_CNT = 4,
    parameter int STUCK_SCANS  = 64
) (
    input  logic       clk_in,
    input  logic       rst_n,
    output logic [3:0] row_drive,
    input  logic [3:0] col_sense,
    output logic [3:0] key_row,
    output logic [3:0] key_column,
`ifdef KEYPAD_STUCK_DET_EN
    output logic       key_stuck,
`endif
    output logic       key_valid
);
    localparam int SLOT_W = $clog2(SCAN_DIV);
    localparam int CNT_W  = $clog2(DEBOUNCE_CNT + 1);

    localparam logic [1:0] ST_SCAN    = 2'd0;
    localparam logic [1:0] ST_DEB     = 2'd1;
    localparam logic [1:0] ST_HOLD    = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    logic [3:0]        cs_meta_q, cs_q;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [1:0]        state_q, state_d;
    logic [3:0]        row_q, row_d;
    logic [3:0]        cand_row_q, cand_row_d, cand_col_q, cand_col_d;
    logic [CNT_W-1:0]  match_q, match_d, rel_q, rel_d;
    logic [3:0]        key_row_q, key_row_d, key_col_q, key_col_d;
    logic              valid_q, valid_d;
    logic              sample;
`ifdef KEYPAD_STUCK_DET_EN
    localparam int HOLD_W = $clog2(STUCK_SCANS + 1);
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              stuck_q, stuck_d;
`endif

    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [3:0] rotate(input logic [3:0] v);
        return {v[2:0], v[3]};
    endfunction

    assign sample = (slot_q == SLOT_W'(SCAN_DIV - 1));

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        slot_d     = sample ? '0 : slot_q + SLOT_W'(1);
        cand_row_d = cand_row_q;
        cand_col_d = cand_col_q;
        match_d    = match_q;
        rel_d      = rel_q;
        key_row_d  = key_row_q;
        key_col_d  = key_col_q;
        valid_d    = 1'b0;
`ifdef KEYPAD_STUCK_DET_EN
        hold_d     = hold_q;
        stuck_d    = stuck_q;
`endif
        case (state_q)
            ST_SCAN: begin
                // Ghosted (multi-bit) or empty columns never start a debounce.
                if (sample) begin
                    if (is_onehot(cs_q)) begin
                        cand_row_d = row_q;
                        cand_col_d = cs_q;
                        match_d    = '0;
                        state_d    = ST_DEB;
                    end else begin
                        row_d = rotate(row_q);
                    end
                end
            end
            ST_DEB: begin
                if (sample) begin
                    if (cs_q == cand_col_q) begin
                        if (match_q != CNT_W'(DEBOUNCE_CNT)) match_d = match_q + CNT_W'(1);
                        if (match_q == CNT_W'(DEBOUNCE_CNT - 1)) begin
                            state_d   = ST_HOLD;
                            key_row_d = cand_row_q;
                            key_col_d = cand_col_q;
                            valid_d   = 1'b1;
                            rel_d     = '0;
`ifdef KEYPAD_STUCK_DET_EN
                            hold_d    = '0;
`endif
                        end
                    end else begin
                        state_d = ST_SCAN;
                        row_d   = rotate(row_q);
                    end
                end
            end
            ST_HOLD: begin
                if (sample) begin
`ifdef KEYPAD_STUCK_DET_EN
                    if (hold_q != HOLD_W'(STUCK_SCANS)) hold_d = hold_q + HOLD_W'(1);
                    if (hold_q == HOLD_W'(STUCK_SCANS - 1)) begin
                        stuck_d   = 1'b1;
                        key_row_d = 4'd0;
                        key_col_d = 4'd0;
                    end
`endif
                    // Only the candidate column matters; a second key cannot be taken.
                    if ((cs_q & cand_col_q) != 4'd0) begin
                        rel_d = '0;
                    end else if (rel_q == CNT_W'(DEBOUNCE_CNT - 1)) begin
                        state_d = ST_RELEASE;
`ifdef KEYPAD_STUCK_DET_EN
                        stuck_d = 1'b0;
`endif
                    end else begin
                        rel_d = rel_q + CNT_W'(1);
                    end
                end
            end
            ST_RELEASE: begin
                key_row_d = 4'd0;
                key_col_d = 4'd0;
                row_d     = 4'b0001;
                slot_d    = '0;
                match_d   = '0;
                rel_d     = '0;
                state_d   = ST_SCAN;
            end
            default: state_d = ST_SCAN;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cs_meta_q  <= 4'd0;
            cs_q       <= 4'd0;
            slot_q     <= '0;
            state_q    <= ST_SCAN;
            row_q      <= 4'b0001;
            cand_row_q <= 4'd0;
            cand_col_q <= 4'd0;
            match_q    <= '0;
            rel_q      <= '0;
            key_row_q  <= 4'd0;
            key_col_q  <= 4'd0;
            valid_q    <= 1'b0;
`ifdef KEYPAD_STUCK_DET_EN
            hold_q     <= '0;
            stuck_q    <= 1'b0;
`endif
        end else begin
            cs_meta_q  <= col_sense;
            cs_q       <= cs_meta_q;
            slot_q     <= slot_d;
            state_q    <= state_d;
            row_q      <= row_d;
            cand_row_q <= cand_row_d;
            cand_col_q <= cand_col_d;
            match_q    <= match_d;
            rel_q      <= rel_d;
            key_row_q  <= key_row_d;
            key_col_q  <= key_col_d;
            valid_q    <= valid_d;
`ifdef KEYPAD_STUCK_DET_EN
            hold_q     <= hold_d;
            stuck_q    <= stuck_d;
`endif
        end
    end

    assign row_drive  = row_q;
    assign key_row    = key_row_q;
    assign key_column = key_col_q;
    assign key_valid  = valid_q;
`ifdef KEYPAD_STUCK_DET_EN
    assign key_stuck  = stuck_q;
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed testbench for keypad_scanner with a behavioural 4x4 matrix model.
module tb_keypad_scanner;
    logic       clk_in = 1'b0;
    logic       rst_n  = 1'b0;
    logic [3:0] row_drive, col_sense, key_row, key_column;
    logic       key_valid;
`ifdef KEYPAD_STUCK_DET_EN
    logic       key_stuck;
`endif
    logic       press_on  = 1'b0;
    logic [3:0] press_row = 4'b0001;
    logic [3:0] press_col = 4'b0001;
    int total = 0, bad = 0;
    int vld_cnt = 0, vld_zero = 0;

    always #5 clk_in = ~clk_in;

    assign col_sense = (press_on && ((row_drive & press_row) != 4'd0)) ? press_col : 4'd0;

    keypad_scanner dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .row_drive (row_drive),
        .col_sense (col_sense),
        .key_row   (key_row),
        .key_column(key_column),
`ifdef KEYPAD_STUCK_DET_EN
        .key_stuck (key_stuck),
`endif
        .key_valid (key_valid)
    );

    always @(negedge clk_in) begin
        if (key_valid) begin
            vld_cnt++;
            if (key_row == 4'd0 || key_column == 4'd0) vld_zero++;
        end
    end

    task automatic start(input logic [3:0] r, input logic [3:0] c, input logic on);
        press_row = r;
        press_col = c;
        press_on  = on;
        rst_n     = 1'b0;
        repeat (2) @(negedge clk_in);
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(input int limit, output int n);
        n = 0;
        do begin
            @(posedge clk_in); #1;
            n++;
        end while (!key_valid && n < limit);
    endtask

    task automatic wait_clear(input int limit, output int n);
        n = 0;
        do begin
            @(posedge clk_in); #1;
            n++;
        end while ((key_row != 4'd0 || key_column != 4'd0) && n < limit);
    endtask

    task automatic test_reset;
        start(4'b0001, 4'b0001, 1'b0);
        repeat (40) @(posedge clk_in);
        #1;
        total++;
        if (row_drive !== 4'b0100) begin bad++; $display("FAIL rst_rot_pre got=%b exp=0100", row_drive); end
        #3 rst_n = 1'b0;
        #1;
        total++;
        if ({row_drive, key_row, key_column, key_valid} !== {4'b0001, 4'd0, 4'd0, 1'b0}) begin
            bad++; $display("FAIL rst_async row=%b kr=%b kc=%b kv=%b exp=0001/0000/0000/0", row_drive, key_row, key_column, key_valid);
        end
        @(negedge clk_in) rst_n = 1'b1;
        repeat (15) @(posedge clk_in);
        #1;
        total++;
        if (row_drive !== 4'b0001) begin bad++; $display("FAIL rst_rot15 got=%b exp=0001", row_drive); end
        @(posedge clk_in); #1;
        total++;
        if (row_drive !== 4'b0010) begin bad++; $display("FAIL rst_rot16 got=%b exp=0010", row_drive); end
    endtask

    task automatic test_clean_press;
        int n, v0, errs;
        v0 = vld_cnt;
        start(4'b1000, 4'b0001, 1'b1);
        wait_valid(300, n);
        total++;
        if (n != 128) begin bad++; $display("FAIL press_latency got=%0d exp=128", n); end
        total++;
        if ({key_row, key_column} !== {4'b1000, 4'b0001}) begin bad++; $display("FAIL press_code got=%b/%b exp=1000/0001", key_row, key_column); end
        @(posedge clk_in); #1;
        total++;
        if (key_valid !== 1'b0) begin bad++; $display("FAIL press_pulse_width got=%b exp=0", key_valid); end
        errs = 0;
        for (int i = 0; i < 319; i++) begin
            @(posedge clk_in); #1;
            if ({key_row, key_column} !== {4'b1000, 4'b0001}) errs++;
        end
        total++;
        if (errs != 0) begin bad++; $display("FAIL press_hold errors=%0d exp=0", errs); end
        total++;
        if (vld_cnt - v0 != 1) begin bad++; $display("FAIL press_pulses got=%0d exp=1", vld_cnt - v0); end
        press_on = 1'b0;
        wait_clear(200, n);
        total++;
        if (n != 65) begin bad++; $display("FAIL release_latency got=%0d exp=65", n); end
        total++;
        if (row_drive !== 4'b0001) begin bad++; $display("FAIL release_row got=%b exp=0001", row_drive); end
    endtask

    task automatic test_bounce;
        int v0;
        v0 = vld_cnt;
        start(4'b0001, 4'b0001, 1'b1);
        repeat (16) @(posedge clk_in);
        #1 press_on = 1'b0;
        repeat (16) @(posedge clk_in);
        #1 press_on = 1'b1;
        repeat (16) @(posedge clk_in);
        #1 press_on = 1'b0;
        repeat (8) @(posedge clk_in);
        #1;
        total++;
        if (row_drive !== 4'b0100) begin bad++; $display("FAIL bounce_scan got=%b exp=0100", row_drive); end
        repeat (100) @(posedge clk_in);
        #1;
        total++;
        if ({key_row, key_column} !== 8'h00) begin bad++; $display("FAIL bounce_out got=%b/%b exp=0000/0000", key_row, key_column); end
        total++;
        if (vld_cnt != v0) begin bad++; $display("FAIL bounce_pulses got=%0d exp=0", vld_cnt - v0); end
    endtask

    task automatic test_ghost;
        int v0;
        v0 = vld_cnt;
        start(4'b0001, 4'b0011, 1'b1);
        repeat (56) @(posedge clk_in);
        #1;
        total++;
        if (row_drive !== 4'b1000) begin bad++; $display("FAIL ghost_scan got=%b exp=1000", row_drive); end
        repeat (100) @(posedge clk_in);
        #1;
        total++;
        if ({key_row, key_column} !== 8'h00) begin bad++; $display("FAIL ghost_out got=%b/%b exp=0000/0000", key_row, key_column); end
        total++;
        if (vld_cnt != v0) begin bad++; $display("FAIL ghost_pulses got=%0d exp=0", vld_cnt - v0); end
    endtask

    task automatic test_second_key;
        int n, v0, errs;
        v0 = vld_cnt;
        start(4'b0001, 4'b0010, 1'b1);
        wait_valid(300, n);
        total++;
        if (n != 80) begin bad++; $display("FAIL second_latency got=%0d exp=80", n); end
        press_col = 4'b0110;
        errs = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk_in); #1;
            if ({key_row, key_column} !== {4'b0001, 4'b0010}) errs++;
        end
        total++;
        if (errs != 0) begin bad++; $display("FAIL second_hold errors=%0d exp=0", errs); end
        total++;
        if (vld_cnt - v0 != 1) begin bad++; $display("FAIL second_pulses got=%0d exp=1", vld_cnt - v0); end
        press_on = 1'b0;
        wait_clear(200, n);
        total++;
        if (n != 57) begin bad++; $display("FAIL second_release got=%0d exp=57", n); end
    endtask

    task automatic test_reset_hold;
        int n;
        start(4'b0100, 4'b0100, 1'b1);
        wait_valid(300, n);
        total++;
        if (n != 112 || {key_row, key_column} !== {4'b0100, 4'b0100}) begin
            bad++; $display("FAIL rhold_accept n=%0d code=%b/%b exp=112 0100/0100", n, key_row, key_column);
        end
        repeat (5) @(posedge clk_in);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({key_row, key_column, key_valid} !== 9'h000) begin
            bad++; $display("FAIL rhold_clear got=%b/%b/%b exp=0000/0000/0", key_row, key_column, key_valid);
        end
        @(negedge clk_in) rst_n = 1'b1;
        wait_valid(300, n);
        total++;
        if (n != 112 || {key_row, key_column} !== {4'b0100, 4'b0100}) begin
            bad++; $display("FAIL rhold_repress n=%0d code=%b/%b exp=112 0100/0100", n, key_row, key_column);
        end
        press_on = 1'b0;
        wait_clear(200, n);
        total++;
        if (n != 65) begin bad++; $display("FAIL rhold_release got=%0d exp=65", n); end
    endtask

`ifdef KEYPAD_STUCK_DET_EN
    task automatic test_stuck;
        int n, v0;
        v0 = vld_cnt;
        start(4'b0001, 4'b0001, 1'b1);
        wait_valid(300, n);
        total++;
        if (n != 80) begin bad++; $display("FAIL stuck_accept got=%0d exp=80", n); end
        repeat (1023) @(posedge clk_in);
        #1;
        total++;
        if (key_stuck !== 1'b0 || key_row !== 4'b0001) begin bad++; $display("FAIL stuck_early st=%b kr=%b exp=0/0001", key_stuck, key_row); end
        @(posedge clk_in); #1;
        total++;
        if ({key_stuck, key_row, key_column} !== 9'h100) begin
            bad++; $display("FAIL stuck_set st=%b kr=%b kc=%b exp=1/0000/0000", key_stuck, key_row, key_column);
        end
        repeat (96) @(posedge clk_in);
        #1;
        total++;
        if (vld_cnt - v0 != 1) begin bad++; $display("FAIL stuck_pulses got=%0d exp=1", vld_cnt - v0); end
        press_on = 1'b0;
        n = 0;
        do begin
            @(posedge clk_in); #1;
            n++;
        end while (key_stuck && n < 200);
        total++;
        if (key_stuck !== 1'b0) begin bad++; $display("FAIL stuck_clear got=%b exp=0", key_stuck); end
    endtask
`endif

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_ghost();
        test_second_key();
        test_reset_hold();
`ifdef KEYPAD_STUCK_DET_EN
        test_stuck();
`endif
        total++;
        if (vld_zero != 0) begin bad++; $display("FAIL valid_with_zero_code got=%0d exp=0", vld_zero); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
